irq_sched_ctrl: RTL and testbench
=================================

// Module: irq_sched_ctrl
// PURPOSE
//  Interrupt scheduler between the hardware interrupt sources and the CPU's CP0 interrupt input.
//  Sources: TC0 IRQ, TC1 IRQ, external interrupt pin and three spare lines.
//  Latches, masks and prioritises the sources, then presents one granted source at a time to the CPU.
//  Tracks service until ERET; on entry to an external-interrupt handler, issues the one-cycle acknowledge write to the interrupt generator.
//  Configured through a small word-addressed slave port decoded by the Bridge.
// PARAMETERS
//  N_SRC         6            number of interrupt sources (bit i = HWInt[i]); max 8
//  EXT_IDX       2            source index of the external interrupt pin
//  INT_ACK_ADDR  32'h0000_7F20  address driven on ack_addr during the external acknowledge
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  irq_src      in   N_SRC  raw source lines {spare,spare,spare,interrupt,IRQ_1,IRQ_0}
//  reg_addr     in   4      byte offset within the block; word aligned; bits[1:0] ignored
//  reg_we       in   1      register write strobe from the Bridge
//  reg_wdata    in   32     register write data
//  reg_rdata    out  32     register read data, combinational on reg_addr
//  hwint        out  N_SRC  one-hot granted source to CP0; all zero when none is granted
//  cpu_int_ack  in   1      CPU took the interrupt this cycle (Intrespon)
//  cpu_eret     in   1      ERET retired in the CPU this cycle
//  in_service   out  1      a granted source is being serviced
//  ack_addr     out  32     acknowledge write address to the interrupt generator
//  ack_byteen   out  4      acknowledge write byte enable
// BEHAVIOUR
//  Registers (offset: name, reset value):
//  - 0x0 MASK, 0: bit=1 enables the source.
//  - 0x4 EDGE, 1<<EXT_IDX: bit=1 makes the source edge-sensitive; bit=0 makes it level-sensitive.
//  - 0x8 PEND, 0: edge-source latches; write 1 to clear; read returns eff_pend.
//  - 0xC CUR, 0: read only; {in_service, 28'b0, cur_id[2:0]}.
//  Writes to CUR are ignored. Unused bits read 0.
//  Edge sources: the PEND bit sets on a 0->1 of irq_src against a registered sample.
//  - Set and W1C on the same cycle: set wins.
//  Level sources: eff_pend[i] = irq_src[i]. PEND[i] stays 0 for level sources.
//  Request vector: req = eff_pend & MASK. The lowest index has the highest priority.
//  Register writes take effect on the next cycle. The request vector is evaluated every cycle in IDLE.
//  FSM, 3 states:
//  - IDLE: hwint=0. If req!=0, latch cur_id = priority winner and go to GRANT.
//  - GRANT: hwint = 1<<cur_id.
//    - cpu_int_ack=1: go to SERVICE. If the source is edge-sensitive, clear its PEND bit on the same edge.
//    - Otherwise, if req[cur_id]=0 (source dropped or masked): go to IDLE; hwint drops next cycle.
//    - If ack and drop happen on the same cycle, ack wins.
//    - A higher-priority arrival during GRANT does NOT preempt; cur_id is fixed.
//  - SERVICE: hwint=0, in_service=1. No nesting; new requests stay pending.
//    - cpu_eret=1: go to IDLE. A pending request is granted one cycle later, never on the ERET cycle.
//  cpu_int_ack outside GRANT and cpu_eret outside SERVICE are ignored.
//  External acknowledge, registered:
//  - When the GRANT->SERVICE transition has cur_id==EXT_IDX, the next cycle drives ack_addr=INT_ACK_ADDR and ack_byteen=4'b0001.
//  - This lasts exactly 1 cycle. Otherwise ack_addr=0 and ack_byteen=0.
//  Reset (async, any state, including mid-GRANT or mid-ack):
//  - state=IDLE; MASK, PEND and CUR take their reset values.
//  - hwint=0, in_service=0, ack_addr=0, ack_byteen=0.
//  - The edge sample register takes 0, so a source held high through reset sets PEND on the first clock.
//  All outputs except reg_rdata are registered.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/GRANT/SERVICE), register offset constants, INT_ACK_ADDR default.
//  One sub-module: irq_prio_enc. Combinational N_SRC->{valid,id[2:0]}, lowest index first.
//  The FSM, registers and edge detection live in irq_sched_ctrl.
// TESTING
//  1. MASK=1, irq_src[0] held 1 -> hwint=6'b000001 the 2nd cycle after the MASK write; ack -> SERVICE; eret -> IDLE, then re-grant 1 cycle later (level).
//  2. MASK=6'h07, irq_src[2:0] rise on the same cycle -> grant id 0; after eret, grant id 1; after eret, grant id 2.
//  3. EXT: MASK=4, pulse irq_src[2] for 1 cycle, ack -> PEND[2] clears; the next cycle ack_addr=0x7F20 and ack_byteen=1 for exactly 1 cycle.
//  4. Level id1 in GRANT, clear MASK[1] before ack -> IDLE, hwint=0 next cycle, no ack write.
//  5. Edge on id2 together with W1C PEND=4 on the same cycle -> PEND[2] reads 1.
//  6. reset=0 asynchronously during the ack-write cycle -> ack_byteen=0 and hwint=0 immediately; PEND=0; MASK=0.

Source files
------------

// File: rtl/irq_sched_ctrl_pkg.sv
// Shared definitions for the interrupt scheduler.
// Contents: FSM state type, register word indices (reg_addr[3:2]),
// default acknowledge address and byte enable.
package irq_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Word indices of the registers.
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_CUR  = 2'd3;

  localparam logic [31:0] INT_ACK_ADDR_DEF = 32'h0000_7F20;
  localparam logic [3:0]  ACK_BYTEEN       = 4'b0001;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
// Ports:
//   i_req   [N_SRC-1:0]  request vector
//   o_valid              at least one request set
//   o_id    [2:0]        index of the winning request (0 when none)
module irq_prio_enc #(
  parameter int unsigned N_SRC = 6
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_valid,
  output logic [2:0]       o_id
);

  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (i_req[i] && !o_valid) begin
        o_valid = 1'b1;
        o_id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_sched_ctrl.sv
// Interrupt scheduler between hardware interrupt sources and the CPU's
// CP0 interrupt input. Latches edge sources, masks and prioritises
// requests, presents one granted source at a time, tracks service until
// ERET and issues a one-cycle acknowledge write for the external source.
// Ports:
//   clk, reset (async, active low)
//   irq_src     [N_SRC-1:0]  raw source lines
//   reg_addr/reg_we/reg_wdata/reg_rdata  word-addressed register port
//   hwint       [N_SRC-1:0]  one-hot granted source to CP0
//   cpu_int_ack, cpu_eret    CPU handshake
//   in_service               granted source is being serviced
//   ack_addr, ack_byteen     acknowledge write to the interrupt generator
module irq_sched_ctrl
  import irq_sched_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC        = 6,
  parameter int unsigned EXT_IDX      = 2,
  parameter logic [31:0] INT_ACK_ADDR = INT_ACK_ADDR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [3:0]       reg_addr,
  input  logic             reg_we,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic [N_SRC-1:0] hwint,
  input  logic             cpu_int_ack,
  input  logic             cpu_eret,
  output logic             in_service,
  output logic [31:0]      ack_addr,
  output logic [3:0]       ack_byteen
);

  state_t           r_state;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_edge;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_sample;
  logic [N_SRC-1:0] r_hwint;
  logic [2:0]       r_cur_id;
  logic             r_in_service;
  logic [31:0]      r_ack_addr;
  logic [3:0]       r_ack_byteen;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_eff_pend;
  logic [N_SRC-1:0] w_req;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_cur_onehot;
  logic             w_cur_req;
  logic             w_take;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic             w_wr_pend;
  logic             w_win_valid;
  logic [2:0]       w_win_id;
  logic             w_unused;

  assign w_wr_mask = reg_we && (reg_addr[3:2] == REG_MASK);
  assign w_wr_edge = reg_we && (reg_addr[3:2] == REG_EDGE);
  assign w_wr_pend = reg_we && (reg_addr[3:2] == REG_PEND);

  // Level sources bypass PEND; edge sources only request through PEND.
  assign w_rise     = irq_src & ~r_sample & r_edge;
  assign w_eff_pend = (r_pend & r_edge) | (irq_src & ~r_edge);
  assign w_req      = w_eff_pend & r_mask;

  assign w_cur_onehot = N_SRC'(1) << r_cur_id;
  assign w_cur_req    = |(w_req & w_cur_onehot);
  assign w_take       = (r_state == ST_GRANT) && cpu_int_ack;

  // A new rising edge outranks both the W1C clear and the ack clear.
  assign w_w1c      = w_wr_pend ? reg_wdata[N_SRC-1:0] : '0;
  assign w_ack_clr  = w_take ? w_cur_onehot : '0;
  assign w_pend_nxt = ((r_pend & ~w_w1c & ~w_ack_clr) | w_rise) & r_edge;

  assign w_unused = &{1'b0, reg_addr[1:0], reg_wdata[31:N_SRC]};

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio (
    .i_req   (w_req),
    .o_valid (w_win_valid),
    .o_id    (w_win_id)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask   <= '0;
      r_edge   <= N_SRC'(1) << EXT_IDX;
      r_pend   <= '0;
      r_sample <= '0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_sample <= irq_src;
      if (w_wr_mask) r_mask <= reg_wdata[N_SRC-1:0];
      if (w_wr_edge) r_edge <= reg_wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cur_id     <= '0;
      r_hwint      <= '0;
      r_in_service <= 1'b0;
      r_ack_addr   <= '0;
      r_ack_byteen <= '0;
    end else begin
      r_ack_addr   <= '0;
      r_ack_byteen <= '0;
      case (r_state)
        ST_IDLE: begin
          r_hwint      <= '0;
          r_in_service <= 1'b0;
          if (w_win_valid) begin
            r_state  <= ST_GRANT;
            r_cur_id <= w_win_id;
            r_hwint  <= N_SRC'(1) << w_win_id;
          end
        end
        ST_GRANT: begin
          if (cpu_int_ack) begin
            r_state      <= ST_SERVICE;
            r_hwint      <= '0;
            r_in_service <= 1'b1;
            if (r_cur_id == 3'(EXT_IDX)) begin
              r_ack_addr   <= INT_ACK_ADDR;
              r_ack_byteen <= ACK_BYTEEN;
            end
          end else if (!w_cur_req) begin
            r_state <= ST_IDLE;
            r_hwint <= '0;
          end
        end
        ST_SERVICE: begin
          if (cpu_eret) begin
            r_state      <= ST_IDLE;
            r_in_service <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_hwint      <= '0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr[3:2])
      REG_MASK: reg_rdata[N_SRC-1:0] = r_mask;
      REG_EDGE: reg_rdata[N_SRC-1:0] = r_edge;
      REG_PEND: reg_rdata[N_SRC-1:0] = w_eff_pend;
      REG_CUR:  reg_rdata = {r_in_service, 28'b0, r_cur_id};
      default:  reg_rdata = '0;
    endcase
  end

  assign hwint      = r_hwint;
  assign in_service = r_in_service;
  assign ack_addr   = r_ack_addr;
  assign ack_byteen = r_ack_byteen;

endmodule

// File: tb/tb_irq_sched_ctrl.sv
module tb_irq_sched_ctrl;

  localparam int unsigned N = 6;

  logic          clk;
  logic          reset;
  logic [N-1:0]  irq_src;
  logic [3:0]    reg_addr;
  logic          reg_we;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic [N-1:0]  hwint;
  logic          cpu_int_ack;
  logic          cpu_eret;
  logic          in_service;
  logic [31:0]   ack_addr;
  logic [3:0]    ack_byteen;

  int n_pass = 0;
  int n_tot  = 0;

  irq_sched_ctrl #(
    .N_SRC        (N),
    .EXT_IDX      (2),
    .INT_ACK_ADDR (32'h0000_7F20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .reg_addr    (reg_addr),
    .reg_we      (reg_we),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .hwint       (hwint),
    .cpu_int_ack (cpu_int_ack),
    .cpu_eret    (cpu_eret),
    .in_service  (in_service),
    .ack_addr    (ack_addr),
    .ack_byteen  (ack_byteen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    chk(nm, reg_rdata, exp);
  endtask

  task automatic do_reset();
    irq_src = '0; cpu_int_ack = 1'b0; cpu_eret = 1'b0;
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Register-port vectors: optional write, then a read-back.
  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  // Behavioural reference: scheduler seen as "free / offered / serving".
  logic [N-1:0] m_mask, m_edge, m_pend, m_samp, m_hw;
  logic [2:0]   m_cur;
  int           m_mode;
  logic         m_srv;
  logic [3:0]   m_be;

  task automatic m_reset();
    m_mask = '0; m_edge = 6'b000100; m_pend = '0; m_samp = '0; m_hw = '0;
    m_cur = '0; m_mode = 0; m_srv = 1'b0; m_be = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic [N-1:0] src);
    logic [N-1:0] eff;
    eff = (m_pend & m_edge) | (src & ~m_edge);
    case (a[3:2])
      2'd0:    return {26'd0, m_mask};
      2'd1:    return {26'd0, m_edge};
      2'd2:    return {26'd0, eff};
      default: return {m_srv, 28'd0, m_cur};
    endcase
  endfunction

  task automatic m_step(input logic [N-1:0] src, input logic we, input logic [3:0] a,
                        input logic [31:0] d, input logic ack, input logic eret);
    logic [N-1:0] eff, req, low, rise, w1c, clr;
    eff  = (m_pend & m_edge) | (src & ~m_edge);
    req  = eff & m_mask;
    low  = req & (~req + 6'd1);
    rise = src & ~m_samp & m_edge;
    w1c  = (we && a[3:2] == 2'd2) ? d[N-1:0] : '0;
    clr  = '0;
    m_be = '0;
    if (m_mode == 0) begin
      if (req != 0) begin
        m_mode = 1;
        m_cur  = 3'($clog2(low));
        m_hw   = low;
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        m_mode = 2; m_hw = '0; m_srv = 1'b1;
        clr = 6'd1 << m_cur;
        if (m_cur == 3'd2) m_be = 4'b0001;
      end else if (!req[m_cur]) begin
        m_mode = 0; m_hw = '0;
      end
    end else begin
      if (eret) begin
        m_mode = 0; m_srv = 1'b0;
      end
    end
    m_pend = ((m_pend & ~w1c & ~clr) | rise) & m_edge;
    m_samp = src;
    if (we && a[3:2] == 2'd0) m_mask = d[N-1:0];
    if (we && a[3:2] == 2'd1) m_edge = d[N-1:0];
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000_0000};
    tbl[1] = '{1'b0, 4'h0, 32'h0,        4'h4, 32'h0000_0004};
    tbl[2] = '{1'b0, 4'h0, 32'h0,        4'h8, 32'h0000_0000};
    tbl[3] = '{1'b0, 4'h0, 32'h0,        4'hC, 32'h0000_0000};
    tbl[4] = '{1'b1, 4'h0, 32'hFFFF_FFFF, 4'h0, 32'h0000_003F};
    tbl[5] = '{1'b1, 4'h4, 32'h0000_0015, 4'h4, 32'h0000_0015};
    tbl[6] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hC, 32'h0000_0000};
    tbl[7] = '{1'b1, 4'h3, 32'h0000_000A, 4'h0, 32'h0000_000A};
    tbl[8] = '{1'b1, 4'h8, 32'h0000_003F, 4'h8, 32'h0000_0000};
    tbl[9] = '{1'b1, 4'h6, 32'h0000_003F, 4'h5, 32'h0000_003F};

    do_reset();
    chk("rst_hwint", {26'd0, hwint}, 32'h0);
    chk("rst_in_service", {31'd0, in_service}, 32'h0);
    chk("rst_ack_byteen", {28'd0, ack_byteen}, 32'h0);
    chk("rst_ack_addr", ack_addr, 32'h0);

    foreach (tbl[k]) begin
      if (tbl[k].we) wr(tbl[k].addr, tbl[k].wdata);
      rd_chk($sformatf("tbl%0d_rdata", k), tbl[k].raddr, tbl[k].exp);
    end

    // 1: level source 0, grant / service / re-grant after ERET
    do_reset();
    irq_src = 6'b000001;
    wr(4'h0, 32'h1);
    chk("t1_hwint_c1", {26'd0, hwint}, 32'h0);
    tick();
    chk("t1_hwint_c2", {26'd0, hwint}, 32'h1);
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    chk("t1_svc_hwint", {26'd0, hwint}, 32'h0);
    chk("t1_svc_in_service", {31'd0, in_service}, 32'h1);
    chk("t1_svc_byteen", {28'd0, ack_byteen}, 32'h0);
    cpu_eret = 1'b1; tick(); cpu_eret = 1'b0;
    chk("t1_eret_hwint", {26'd0, hwint}, 32'h0);
    chk("t1_eret_in_service", {31'd0, in_service}, 32'h0);
    tick();
    chk("t1_regrant", {26'd0, hwint}, 32'h1);
    irq_src = '0; tick();
    chk("t1_drop", {26'd0, hwint}, 32'h0);

    // 2: three simultaneous edges served in priority order
    do_reset();
    wr(4'h4, 32'h7);
    wr(4'h0, 32'h7);
    irq_src = 6'b000111; tick();
    chk("t2_latch_hwint", {26'd0, hwint}, 32'h0);
    tick();
    chk("t2_grant0", {26'd0, hwint}, 32'h1);
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    chk("t2_svc0", {31'd0, in_service}, 32'h1);
    rd_chk("t2_pend_after_ack0", 4'h8, 32'h6);
    rd_chk("t2_cur_svc0", 4'hC, 32'h8000_0000);
    cpu_eret = 1'b1; tick(); cpu_eret = 1'b0;
    chk("t2_eret0_hwint", {26'd0, hwint}, 32'h0);
    tick();
    chk("t2_grant1", {26'd0, hwint}, 32'h2);
    rd_chk("t2_cur1", 4'hC, 32'h1);
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    cpu_eret = 1'b1; tick(); cpu_eret = 1'b0;
    tick();
    chk("t2_grant2", {26'd0, hwint}, 32'h4);
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    chk("t2_ack2_byteen", {28'd0, ack_byteen}, 32'h1);
    chk("t2_ack2_addr", ack_addr, 32'h0000_7F20);

    // 3: external pulse, PEND clear on ack, single-cycle ack write
    do_reset();
    wr(4'h0, 32'h4);
    irq_src = 6'b000100; tick(); irq_src = '0;
    rd_chk("t3_pend_set", 4'h8, 32'h4);
    tick();
    chk("t3_grant", {26'd0, hwint}, 32'h4);
    chk("t3_byteen_pre", {28'd0, ack_byteen}, 32'h0);
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    rd_chk("t3_pend_clr", 4'h8, 32'h0);
    chk("t3_ack_byteen", {28'd0, ack_byteen}, 32'h1);
    chk("t3_ack_addr", ack_addr, 32'h0000_7F20);
    tick();
    chk("t3_ack_byteen_end", {28'd0, ack_byteen}, 32'h0);
    chk("t3_ack_addr_end", ack_addr, 32'h0);

    // 4: level id1 masked while granted
    do_reset();
    irq_src = 6'b000010;
    wr(4'h0, 32'h2);
    tick();
    chk("t4_grant", {26'd0, hwint}, 32'h2);
    wr(4'h0, 32'h0);
    chk("t4_still_grant", {26'd0, hwint}, 32'h2);
    tick();
    chk("t4_drop_hwint", {26'd0, hwint}, 32'h0);
    chk("t4_drop_byteen", {28'd0, ack_byteen}, 32'h0);
    rd_chk("t4_cur", 4'hC, 32'h1);
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    chk("t4_idle_ack_ignored", {31'd0, in_service}, 32'h0);

    // 5: edge and W1C in the same cycle, then a plain W1C
    do_reset();
    irq_src = 6'b000100;
    reg_we = 1'b1; reg_addr = 4'h8; reg_wdata = 32'h4;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
    rd_chk("t5_set_wins", 4'h8, 32'h4);
    wr(4'h8, 32'h4);
    rd_chk("t5_w1c", 4'h8, 32'h0);

    // 6: asynchronous reset during the ack-write cycle
    do_reset();
    wr(4'h0, 32'h4);
    irq_src = 6'b000100; tick(); irq_src = '0;
    tick();
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    chk("t6_byteen_before", {28'd0, ack_byteen}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_byteen_async", {28'd0, ack_byteen}, 32'h0);
    chk("t6_addr_async", ack_addr, 32'h0);
    chk("t6_hwint_async", {26'd0, hwint}, 32'h0);
    chk("t6_in_service_async", {31'd0, in_service}, 32'h0);
    rd_chk("t6_mask", 4'h0, 32'h0);
    rd_chk("t6_pend", 4'h8, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Randomised run against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] s;
      logic         we, ack, eret;
      logic [3:0]   a;
      logic [31:0]  d;
      s    = ($urandom_range(3) == 0) ? N'($urandom) : irq_src;
      we   = ($urandom_range(7) == 0);
      a    = 4'($urandom);
      d    = $urandom;
      ack  = ($urandom_range(2) == 0);
      eret = ($urandom_range(3) == 0);
      irq_src = s; reg_we = we; reg_addr = a; reg_wdata = d;
      cpu_int_ack = ack; cpu_eret = eret;
      #1;
      chk($sformatf("rnd_rdata@%0d", i), reg_rdata, m_read(a, s));
      @(posedge clk);
      m_step(s, we, a, d, ack, eret);
      #1;
      chk($sformatf("rnd_hwint@%0d", i), {26'd0, hwint}, {26'd0, m_hw});
      chk($sformatf("rnd_in_service@%0d", i), {31'd0, in_service}, {31'd0, m_srv});
      chk($sformatf("rnd_byteen@%0d", i), {28'd0, ack_byteen}, {28'd0, m_be});
      chk($sformatf("rnd_ack_addr@%0d", i), ack_addr, (m_be != 0) ? 32'h0000_7F20 : 32'h0);
    end
    reg_we = 1'b0; cpu_int_ack = 1'b0; cpu_eret = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
